i2s_rx_axis: RTL and testbench

- Captures serial audio from the Pmod I2S2 ADC, with I2S bus signals oversampled in the system clock domain.
- Deserializes each channel slot into a signed DATA_WIDTH word.
- Emits words on an AXI-Stream master that feeds the FIR stage's slave port directly: left word, then right word, tlast on right.
- Includes a 2-entry output buffer so short downstream stalls do not lose samples; overruns are flagged.

---
 rtl/i2s_pkg.sv | 16 +
 rtl/axis_fifo2.sv | 66 ++++++
 rtl/i2s_rx_axis.sv | 189 ++++++++++++++++++
 tb/tb_i2s_rx_axis.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S capture path and the FIR stage behind it.
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } rx_state_t;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    localparam int DATA_WIDTH_DEF = 24;
    localparam int KEEP_WIDTH_DEF = 6;

endpackage

// File: rtl/axis_fifo2.sv
// Two-entry stream buffer with registered outputs; head entry drives the
// output directly so data stays stable while the consumer stalls.
module axis_fifo2 #(
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [1:0]       cnt;
    logic             pop;

    assign valid = (cnt != 2'd0);
    assign empty = (cnt == 2'd0);
    assign full  = (cnt == 2'd2);
    assign dout  = head;
    assign pop   = valid & ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= 2'd0;
        end else begin
            unique case (cnt)
                2'd0: begin
                    if (push) begin
                        head <= din;
                        cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= din;
                    end else if (push) begin
                        tail <= din;
                        cnt  <= 2'd2;
                    end else if (pop) begin
                        cnt <= 2'd0;
                    end
                end
                default: begin
                    // Full: a pop frees the head, so a same-cycle push fits.
                    if (pop) begin
                        head <= tail;
                        if (push) begin
                            tail <= din;
                        end else begin
                            cnt <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/i2s_rx_axis.sv
// I2S receiver: oversampled bus -> per-channel words on AXI-Stream (tlast = right).
// Define I2S_RX_LEFT_JUSTIFIED_EN for left-justified framing instead of I2S.
module i2s_rx_axis
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int KEEP_WIDTH = KEEP_WIDTH_DEF,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i2s_sclk,
    input  logic                         i2s_lrck,
    input  logic                         i2s_sdata,
    output logic signed [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic [KEEP_WIDTH-1:0]        m_axis_tkeep,
    input  logic                         clear_status,
    output logic                         overflow,
    output logic                         frame_err,
    output logic [CNT_WIDTH-1:0]         overrun_cnt
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_CNT = BW'(DATA_WIDTH - 1);

`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    localparam logic LJ = 1'b1;
`else
    localparam logic LJ = 1'b0;
`endif

    logic sclk_s1, sclk_s2, sclk_d;
    logic lrck_s1, lrck_s2;
    logic sdata_s1, sdata_s2;
    logic lrck_prev, primed;
    logic sclk_rise, frame_edge;

    rx_state_t state, state_nx;
    logic [BW-1:0]         bit_cnt, bit_cnt_nx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  shift_en, word_done, ferr_evt;
    logic                  push_q, chan_q;

    logic [DATA_WIDTH:0]   fifo_dout;
    logic                  fifo_full, fifo_empty;
    logic                  pop, drop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_s1  <= 1'b0;
            sclk_s2  <= 1'b0;
            sclk_d   <= 1'b0;
            lrck_s1  <= 1'b0;
            lrck_s2  <= 1'b0;
            sdata_s1 <= 1'b0;
            sdata_s2 <= 1'b0;
        end else begin
            sclk_s1  <= i2s_sclk;
            sclk_s2  <= sclk_s1;
            sclk_d   <= sclk_s2;
            lrck_s1  <= i2s_lrck;
            lrck_s2  <= lrck_s1;
            sdata_s1 <= i2s_sdata;
            sdata_s2 <= sdata_s1;
        end
    end

    assign sclk_rise  = sclk_s2 & ~sclk_d;
    // The first rise only learns the LRCK level, so a slot already in
    // progress at reset release is never mistaken for a fresh one.
    assign frame_edge = sclk_rise & primed & (lrck_s2 != lrck_prev);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lrck_prev <= 1'b0;
            primed    <= 1'b0;
        end else if (sclk_rise) begin
            lrck_prev <= lrck_s2;
            primed    <= 1'b1;
        end
    end

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shift_en   = 1'b0;
        word_done  = 1'b0;
        ferr_evt   = 1'b0;
        if (sclk_rise) begin
            unique case (state)
                IDLE, HOLD: begin
                    if (frame_edge) begin
                        state_nx   = SHIFT;
                        shift_en   = LJ;
                        bit_cnt_nx = LJ ? BW'(1) : '0;
                    end
                end
                SHIFT: begin
                    if (frame_edge) begin
                        ferr_evt   = 1'b1;
                        shift_en   = LJ;
                        bit_cnt_nx = LJ ? BW'(1) : '0;
                    end else begin
                        shift_en   = 1'b1;
                        bit_cnt_nx = bit_cnt + 1'b1;
                        if (bit_cnt == LAST_CNT) begin
                            word_done = 1'b1;
                            state_nx  = HOLD;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            push_q  <= 1'b0;
            chan_q  <= CH_LEFT;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            push_q  <= word_done;
            if (shift_en) begin
                shreg <= {shreg[DATA_WIDTH-2:0], sdata_s2};
            end
            if (word_done) begin
                chan_q <= (lrck_s2 == CH_RIGHT);
            end
        end
    end

    axis_fifo2 #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (push_q),
        .din    ({chan_q, shreg}),
        .ready  (m_axis_tready),
        .dout   (fifo_dout),
        .valid  (m_axis_tvalid),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign {m_axis_tlast, m_axis_tdata} = fifo_dout;
    assign m_axis_tkeep = {KEEP_WIDTH{~fifo_empty}};

    assign pop  = m_axis_tvalid & m_axis_tready;
    assign drop = push_q & fifo_full & ~pop;

    // A drop or framing error in the same cycle as clear_status wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_status) begin
                overflow <= 1'b0;
            end
            if (ferr_evt) begin
                frame_err <= 1'b1;
            end else if (clear_status) begin
                frame_err <= 1'b0;
            end
            if (drop) begin
                if (clear_status) begin
                    overrun_cnt <= CNT_WIDTH'(1);
                end else if (overrun_cnt != '1) begin
                    overrun_cnt <= overrun_cnt + 1'b1;
                end
            end else if (clear_status) begin
                overrun_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_axis.sv
// Bench for i2s_rx_axis: slot-level stimulus against a queue-based stream model.
module tb_i2s_rx_axis;

    localparam int DW = 24;
    localparam int KW = 6;
    localparam int CW = 16;

`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    localparam bit LJ = 1'b1;
`else
    localparam bit LJ = 1'b0;
`endif
    // sclk periods a slot must last for a full word, and slot-start to tvalid
    localparam int NEED      = LJ ? DW : DW + 1;
    localparam int FIRST_LAT = LJ ? 192 : 200;
    localparam logic [DW-1:0] L_FIRST = LJ ? 24'h800001 : 24'h123456;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } word_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i2s_sclk = 1'b0;
    logic          i2s_lrck = 1'b1;
    logic          i2s_sdata = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic [KW-1:0] m_axis_tkeep;
    logic          clear_status = 1'b0;
    logic          overflow;
    logic          frame_err;
    logic [CW-1:0] overrun_cnt;

    i2s_rx_axis #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i2s_sclk     (i2s_sclk),
        .i2s_lrck     (i2s_lrck),
        .i2s_sdata    (i2s_sdata),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tkeep (m_axis_tkeep),
        .clear_status (clear_status),
        .overflow     (overflow),
        .frame_err    (frame_err),
        .overrun_cnt  (overrun_cnt)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    word_t exp_q[$];
    word_t got_q[$];
    logic  m_ovf = 1'b0;
    logic  m_ferr = 1'b0;
    int    m_cnt = 0;
    logic  cur_lr = 1'b1;
    bit    prev_partial = 1'b0;
    bit    rand_ready = 1'b0;
    int    tv_rise_cyc = -1;
    int    bit_start_cyc = 0;
    int    slot_start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_overflow"}, longint'(overflow), longint'(m_ovf));
        chk({tag, "_frame_err"}, longint'(frame_err), longint'(m_ferr));
        chk({tag, "_overrun_cnt"}, longint'(overrun_cnt), longint'(m_cnt));
    endtask

    // One sclk period = 8 clk: low half then high half, data set on the fall.
    task automatic drive_bit(input logic lr, input logic d, input bit clr);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (j == 0) begin
                bit_start_cyc = cyc;
                i2s_sclk      = 1'b0;
                i2s_lrck      = lr;
                i2s_sdata     = d;
                clear_status  = 1'b0;
            end
            if (j == 4) i2s_sclk = 1'b1;
            if (j == 7 && clr) clear_status = 1'b1;
        end
    endtask

    task automatic send_slot(input logic [DW-1:0] v, input int len, input bit clr_final);
        logic  lr;
        logic  d;
        int    fin;
        word_t w;
        lr     = ~cur_lr;
        cur_lr = lr;
        if (prev_partial) m_ferr = 1'b1;
        fin = LJ ? DW - 1 : DW;
        for (int k = 0; k < len; k++) begin
            if (LJ) d = (k < DW) ? v[DW-1-k] : 1'($urandom);
            else    d = (k >= 1 && k <= DW) ? v[DW-k] : 1'($urandom);
            drive_bit(lr, d, clr_final && (k == fin));
            if (k == 0) slot_start_cyc = bit_start_cyc;
            if (k == fin) begin
                w.last = lr;
                w.data = v;
                if (clr_final) begin
                    m_ovf  = 1'b0;
                    m_ferr = 1'b0;
                    m_cnt  = 0;
                end
                if (exp_q.size() >= 2 && !m_axis_tready) begin
                    m_ovf = 1'b1;
                    if (m_cnt < (1 << CW) - 1) m_cnt++;
                end else begin
                    exp_q.push_back(w);
                end
            end
        end
        prev_partial = (len < NEED);
    endtask

    initial begin : rdy_gen
        forever begin
            @(negedge clk);
            if (rand_ready) m_axis_tready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : cmp
        logic  pv;
        logic  pr;
        word_t pw;
        word_t cur;
        word_t e;
        pv = 1'b0;
        pr = 1'b0;
        pw = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) begin
                pv = 1'b0;
            end else begin
                cur = {m_axis_tlast, m_axis_tdata};
                checks++;
                if (m_axis_tkeep !== (m_axis_tvalid ? 6'h3F : 6'h00)) begin
                    errors++;
                    $display("FAIL tkeep: got %h expected %h", m_axis_tkeep,
                             m_axis_tvalid ? 6'h3F : 6'h00);
                end
                if (pv && !pr) begin
                    checks++;
                    if (!m_axis_tvalid || cur !== pw) begin
                        errors++;
                        $display("FAIL hold: got v=%b %h expected v=1 %h",
                                 m_axis_tvalid, cur, pw);
                    end
                end
                if (m_axis_tvalid && !pv) tv_rise_cyc = cyc;
                if (m_axis_tvalid && m_axis_tready) begin
                    checks++;
                    got_q.push_back(cur);
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_word: got %h expected none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            errors++;
                            $display("FAIL word: got %h expected %h", cur, e);
                        end
                    end
                end
                pv = m_axis_tvalid;
                pr = m_axis_tready;
                pw = cur;
            end
        end
    end

    initial begin : main
        int len;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tvalid", longint'(m_axis_tvalid), 0);
        chk("rst_tdata", longint'(m_axis_tdata), 0);
        chk("rst_tlast", longint'(m_axis_tlast), 0);
        chk("rst_tkeep", longint'(m_axis_tkeep), 0);
        chk("rst_overflow", longint'(overflow), 0);
        chk("rst_frame_err", longint'(frame_err), 0);
        chk("rst_overrun_cnt", longint'(overrun_cnt), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Released in the middle of a right slot: nothing may come out of it.
        for (int i = 0; i < 12; i++) drive_bit(1'b1, 1'($urandom), 1'b0);

        m_axis_tready = 1'b1;
        send_slot(L_FIRST, 32, 1'b0);
        chk("latency", longint'(tv_rise_cyc - slot_start_cyc), FIRST_LAT);
        send_slot(24'hFEDCBA, 32, 1'b0);
        chk("got_two", longint'(got_q.size()), 2);
        if (got_q.size() >= 2) begin
            chk("first_data", longint'(got_q[0].data), longint'(L_FIRST));
            chk("first_last", longint'(got_q[0].last), 0);
            chk("second_data", longint'(got_q[1].data), 64'hFEDCBA);
            chk("second_last", longint'(got_q[1].last), 1);
        end
        check_status("basic");

        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) send_slot(24'($urandom), 32, 1'b0);
        check_status("stall");
        chk("stall_overflow_lit", longint'(overflow), 1);
        chk("stall_cnt_lit", longint'(overrun_cnt), 1);
        m_axis_tready = 1'b1;
        send_slot(24'($urandom), 32, 1'b0);
        chk("stall_drain", longint'(exp_q.size()), 0);

        @(negedge clk);
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        #1;
        chk("clr_overflow", longint'(overflow), 0);
        chk("clr_frame_err", longint'(frame_err), 0);
        chk("clr_cnt", longint'(overrun_cnt), 0);
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
        m_cnt  = 0;

        send_slot(24'($urandom), NEED - 4, 1'b0);
        send_slot(24'($urandom), 32, 1'b0);
        send_slot(24'($urandom), 32, 1'b0);
        check_status("ferr");
        chk("ferr_lit", longint'(frame_err), 1);

        m_axis_tready = 1'b0;
        send_slot(24'($urandom), 32, 1'b0);
        send_slot(24'($urandom), 32, 1'b0);
        send_slot(24'($urandom), 32, 1'b1);
        check_status("clr_drop");
        chk("clr_drop_ovf_lit", longint'(overflow), 1);
        chk("clr_drop_cnt_lit", longint'(overrun_cnt), 1);
        chk("clr_drop_ferr_lit", longint'(frame_err), 0);
        m_axis_tready = 1'b1;
        send_slot(24'($urandom), 32, 1'b0);

        rand_ready = 1'b1;
        send_slot(24'h800001, 32, 1'b0);
        chk("pin_800001", longint'(got_q[$].data), 64'h800001);
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 5) == 0) len = $urandom_range(2, NEED - 1);
            else len = $urandom_range(NEED, 32);
            send_slot(24'($urandom), len, 1'b0);
            check_status("rand");
        end
        send_slot(24'($urandom), 32, 1'b0);
        send_slot(24'($urandom), 32, 1'b0);
        check_status("final");
        repeat (20) @(negedge clk);
        rand_ready = 1'b0;
        chk("final_drain", longint'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
